// File: rtl/rv_multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle controller (master) and the
// datapath plus instruction/data memories (slave).
interface rv_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       instrOpcode;
  logic [2:0]       instrFunct3;
  logic [6:0]       instrFunct7;
  logic             alu_zero;
  logic             alu_lt;
  logic             alu_ltu;
  logic             imem_req;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_op;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instrOpcode, instrFunct3, instrFunct7,
    input  alu_zero, alu_lt, alu_ltu,
    input  imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we,
    output ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_b, alu_op,
    output illegal, bus_err, instret
  );

  modport slave (
    output instrOpcode, instrFunct3, instrFunct7,
    output alu_zero, alu_lt, alu_ltu,
    output imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we,
    input  ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_b, alu_op,
    input  illegal, bus_err, instret
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control FSM for an RV32I subset: sequences fetch, decode, execute,
// memory and writeback, driving every datapath strobe and select (Mealy outputs).
module rv_multicycle_ctrl #(
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 255
) (
  input logic                  clk,
  input logic                  reset,
  rv_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {C_OP, C_OPIMM, C_LUI, C_BRANCH, C_LOAD, C_STORE, C_BAD} iclass_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [7:0] TO_LAST    = 8'(MEM_TO - 1);

  state_t           state;
  iclass_t          cls;
  logic             legal;
  logic             taken;
  logic [3:0]       alu_op_dec;
  logic [1:0]       src_b_dec;
  logic [7:0]       to_cnt;
  logic             wait_expired;
  logic             illegal_q;
  logic             bus_err_q;
  logic [CNT_W-1:0] instret_q;

  logic [2:0] f3;
  logic [6:0] f7;

  assign f3 = bus.instrFunct3;
  assign f7 = bus.instrFunct7;

  always_comb begin
    case (bus.instrOpcode)
      OPC_OP:     cls = C_OP;
      OPC_OPIMM:  cls = C_OPIMM;
      OPC_LUI:    cls = C_LUI;
      OPC_BRANCH: cls = C_BRANCH;
      OPC_LOAD:   cls = C_LOAD;
      OPC_STORE:  cls = C_STORE;
      default:    cls = C_BAD;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (cls)
      C_OP:     legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      C_OPIMM: begin
        case (f3)
          3'b001:  legal = (f7 == F7_BASE);
          3'b101:  legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      C_LUI:    legal = 1'b1;
      C_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
      C_LOAD:   legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
      C_STORE:  legal = (f3 <= 3'b010);
      default:  legal = 1'b0;
    endcase
  end

  // Branch compares always run as SUB, so the flags describe rs1 versus rs2.
  always_comb begin
    case (f3)
      3'b000:  taken = bus.alu_zero;
      3'b001:  taken = ~bus.alu_zero;
      3'b100:  taken = bus.alu_lt;
      3'b101:  taken = ~bus.alu_lt;
      3'b110:  taken = bus.alu_ltu;
      3'b111:  taken = ~bus.alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_op_dec = 4'b0000;
    src_b_dec  = 2'b00;
    case (cls)
      C_OP:     alu_op_dec = {f7[5], f3};
      C_OPIMM: begin
        alu_op_dec = {(f3 == 3'b101) & f7[5], f3};
        src_b_dec  = 2'b01;
      end
      C_BRANCH: alu_op_dec = 4'b1000;
      C_LOAD:   src_b_dec  = 2'b01;
      C_STORE:  src_b_dec  = 2'b10;
      default: begin
        alu_op_dec = 4'b0000;
        src_b_dec  = 2'b00;
      end
    endcase
  end

  assign wait_expired = (to_cnt == TO_LAST);

  // Timeout counter is cleared on every entry to FETCH and MEM; a ready seen in
  // the cycle the count would reach MEM_TO still completes the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      to_cnt    <= 8'd0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.imem_ready) begin
            state <= DECODE;
          end else if (wait_expired) begin
            state     <= TRAP;
            bus_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (legal) begin
            state <= EXEC;
          end else begin
            state     <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          to_cnt <= 8'd0;
          if ((cls == C_LOAD) || (cls == C_STORE)) begin
            state <= MEM;
          end else begin
            state     <= FETCH;
            instret_q <= instret_q + CNT_W'(1);
          end
        end
        MEM: begin
          if (bus.dmem_ready) begin
            to_cnt <= 8'd0;
            if (cls == C_STORE) begin
              state     <= FETCH;
              instret_q <= instret_q + CNT_W'(1);
            end else begin
              state <= WB;
            end
          end else if (wait_expired) begin
            state     <= TRAP;
            bus_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        WB: begin
          state     <= FETCH;
          to_cnt    <= 8'd0;
          instret_q <= instret_q + CNT_W'(1);
        end
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  // Reset gates every strobe because the synchronous reset has not yet moved
  // the state register during the reset cycle itself.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.ir_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.rf_we     = 1'b0;
    bus.wb_sel    = 2'b00;
    bus.alu_src_b = 2'b00;
    bus.alu_op    = 4'b0000;
    if (!reset) begin
      case (state)
        FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_we    = bus.imem_ready;
        end
        EXEC: begin
          bus.alu_op    = alu_op_dec;
          bus.alu_src_b = src_b_dec;
          case (cls)
            C_OP, C_OPIMM: begin
              bus.rf_we = 1'b1;
              bus.pc_we = 1'b1;
            end
            C_LUI: begin
              bus.rf_we  = 1'b1;
              bus.wb_sel = 2'b10;
              bus.pc_we  = 1'b1;
            end
            C_BRANCH: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = taken;
            end
            default: bus.pc_we = 1'b0;
          endcase
        end
        MEM: begin
          bus.alu_op    = alu_op_dec;
          bus.alu_src_b = src_b_dec;
          bus.dmem_req  = 1'b1;
          bus.dmem_we   = (cls == C_STORE);
          bus.pc_we     = (cls == C_STORE) && bus.dmem_ready;
        end
        WB: begin
          bus.alu_op    = alu_op_dec;
          bus.alu_src_b = src_b_dec;
          bus.rf_we     = 1'b1;
          bus.wb_sel    = 2'b01;
          bus.pc_we     = 1'b1;
        end
        default: bus.imem_req = 1'b0;
      endcase
    end
  end

  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed steps followed by random
// instructions, each compared against a per-instruction behavioural model.
module tb_rv_multicycle_ctrl;
  localparam int CNT_W  = 4;
  localparam int MEM_TO = 4;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct {
    bit         retire;
    bit         illegal;
    bit         bus_err;
    int         cycles;
    int         imem_reqs;
    int         ir_wes;
    int         rf_wes;
    int         pc_wes;
    int         dmem_reqs;
    int         dmem_wes;
    logic       pc_sel;
    logic [3:0] alu_op;
    logic [1:0] src_b;
    logic [1:0] wb_sel;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   model_ret = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  rv_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] strobes();
    return 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.rf_we});
  endfunction

  // Instruction-level model: outcome, latency and strobe totals for one instruction.
  function automatic exp_t predict(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic z, input logic lt,
                                   input logic ltu, input int f_wait, input int m_wait);
    exp_t e;
    bit   legal;
    bit   is_mem;
    e = '{default: 0};
    case (op)
      OP_OP:     legal = (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
      OP_OPIMM:  legal = (f3 == 3'd1) ? (f7 == 7'd0) :
                         (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : 1'b1;
      OP_LUI:    legal = 1'b1;
      OP_BRANCH: legal = !(f3 inside {3'd2, 3'd3});
      OP_LOAD:   legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      OP_STORE:  legal = (f3 <= 3'd2);
      default:   legal = 1'b0;
    endcase
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    if (op == OP_OP) e.alu_op = {f7[5], f3};
    else if (op == OP_OPIMM) e.alu_op = {(f3 == 3'd5) ? f7[5] : 1'b0, f3};
    else if (op == OP_BRANCH) e.alu_op = 4'd8;
    e.src_b  = (op == OP_OPIMM || op == OP_LOAD) ? 2'd1 : (op == OP_STORE) ? 2'd2 : 2'd0;
    e.wb_sel = (op == OP_LUI) ? 2'd2 : (op == OP_LOAD) ? 2'd1 : 2'd0;
    if (op == OP_BRANCH) begin
      case (f3)
        3'd0:    e.pc_sel = z;
        3'd1:    e.pc_sel = !z;
        3'd4:    e.pc_sel = lt;
        3'd5:    e.pc_sel = !lt;
        3'd6:    e.pc_sel = ltu;
        default: e.pc_sel = !ltu;
      endcase
    end
    if (f_wait >= MEM_TO) begin
      e.bus_err   = 1;
      e.cycles    = MEM_TO;
      e.imem_reqs = MEM_TO;
    end else if (!legal) begin
      e.illegal   = 1;
      e.cycles    = f_wait + 2;
      e.imem_reqs = f_wait + 1;
      e.ir_wes    = 1;
    end else if (is_mem && m_wait >= MEM_TO) begin
      e.bus_err   = 1;
      e.cycles    = f_wait + 3 + MEM_TO;
      e.imem_reqs = f_wait + 1;
      e.ir_wes    = 1;
      e.dmem_reqs = MEM_TO;
      e.dmem_wes  = (op == OP_STORE) ? MEM_TO : 0;
    end else begin
      e.retire    = 1;
      e.imem_reqs = f_wait + 1;
      e.ir_wes    = 1;
      e.pc_wes    = 1;
      e.dmem_reqs = is_mem ? m_wait + 1 : 0;
      e.dmem_wes  = (op == OP_STORE) ? m_wait + 1 : 0;
      e.rf_wes    = (op inside {OP_OP, OP_OPIMM, OP_LUI, OP_LOAD}) ? 1 : 0;
      e.cycles    = f_wait + 3 + e.dmem_reqs + ((op == OP_LOAD) ? 1 : 0);
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    checkOutput("reset_strobes", strobes(), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model_ret = 0;
    checkOutput("reset_instret", 32'(bus.instret), 32'd0);
    checkOutput("reset_illegal", 32'(bus.illegal), 32'd0);
    checkOutput("reset_bus_err", 32'(bus.bus_err), 32'd0);
  endtask

  // Runs one instruction from FETCH to retirement or trap, then checks totals.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input logic lt, input logic ltu,
                               input int f_wait, input int m_wait);
    exp_t       e;
    int         fetch_seen = 0, mem_seen = 0;
    int         n_imem = 0, n_ir = 0, n_rf = 0, n_pc = 0, n_dreq = 0, n_dwe = 0;
    int         pc_cycle = -1;
    logic       pc_sel_seen = 1'b0;
    logic [3:0] op_seen = 4'd0;
    logic [1:0] srcb_seen = 2'd0, wb_seen = 2'd0;
    e = predict(op, f3, f7, z, lt, ltu, f_wait, m_wait);
    bus.instrOpcode = op;
    bus.instrFunct3 = f3;
    bus.instrFunct7 = f7;
    bus.alu_zero    = z;
    bus.alu_lt      = lt;
    bus.alu_ltu     = ltu;
    for (int c = 0; c < e.cycles; c++) begin
      bus.imem_ready = (fetch_seen == f_wait);
      bus.dmem_ready = (mem_seen == m_wait);
      @(negedge clk);
      if (bus.imem_req) begin n_imem++; fetch_seen++; end
      if (bus.dmem_req) begin n_dreq++; mem_seen++; end
      if (bus.dmem_we) n_dwe++;
      if (bus.ir_we) n_ir++;
      if (bus.rf_we) begin n_rf++; wb_seen = bus.wb_sel; end
      if (bus.pc_we) begin
        n_pc++;
        pc_cycle    = c;
        pc_sel_seen = bus.pc_sel;
        op_seen     = bus.alu_op;
        srcb_seen   = bus.alu_src_b;
      end
      @(posedge clk);
      #1;
    end
    if (e.retire) model_ret++;
    checkOutput("imem_req_cycles", 32'(n_imem), 32'(e.imem_reqs));
    checkOutput("ir_we_cycles", 32'(n_ir), 32'(e.ir_wes));
    checkOutput("rf_we_cycles", 32'(n_rf), 32'(e.rf_wes));
    checkOutput("pc_we_cycles", 32'(n_pc), 32'(e.pc_wes));
    checkOutput("dmem_req_cycles", 32'(n_dreq), 32'(e.dmem_reqs));
    checkOutput("dmem_we_cycles", 32'(n_dwe), 32'(e.dmem_wes));
    checkOutput("illegal", 32'(bus.illegal), 32'(e.illegal));
    checkOutput("bus_err", 32'(bus.bus_err), 32'(e.bus_err));
    checkOutput("instret", 32'(bus.instret), 32'(model_ret % (1 << CNT_W)));
    if (e.retire) begin
      checkOutput("retire_cycle", 32'(pc_cycle), 32'(e.cycles - 1));
      checkOutput("pc_sel", 32'(pc_sel_seen), 32'(e.pc_sel));
      checkOutput("alu_op", 32'(op_seen), 32'(e.alu_op));
      checkOutput("alu_src_b", 32'(srcb_seen), 32'(e.src_b));
      if (e.rf_wes == 1) checkOutput("wb_sel", 32'(wb_seen), 32'(e.wb_sel));
    end else begin
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checkOutput("trap_strobes", strobes(), 32'd0);
        @(posedge clk);
        #1;
      end
      checkOutput("trap_instret", 32'(bus.instret), 32'(model_ret % (1 << CNT_W)));
      do_reset();
    end
  endtask

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    int         fw, mw, pick;
    bus.instrOpcode = OP_OP;
    bus.instrFunct3 = 3'd0;
    bus.instrFunct7 = 7'd0;
    bus.alu_zero    = 1'b0;
    bus.alu_lt      = 1'b0;
    bus.alu_ltu     = 1'b0;
    bus.imem_ready  = 1'b1;
    bus.dmem_ready  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back ADDs, then immediate shifts, SUB and an illegal funct7.
    repeat (3) applyStimulus(OP_OP, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    applyStimulus(OP_OPIMM, 3'd5, 7'b0100000, 0, 0, 0, 0, 0);
    applyStimulus(OP_OP, 3'd0, 7'b0100000, 0, 0, 0, 0, 0);
    applyStimulus(OP_LUI, 3'd3, 7'd5, 0, 0, 0, 1, 0);
    applyStimulus(OP_OP, 3'd0, 7'b0000001, 0, 0, 0, 0, 0);

    // Branch resolution and an illegal branch funct3.
    applyStimulus(OP_BRANCH, 3'd1, 7'd0, 0, 0, 0, 0, 0);
    applyStimulus(OP_BRANCH, 3'd1, 7'd0, 1, 0, 0, 0, 0);
    applyStimulus(OP_BRANCH, 3'd6, 7'd0, 0, 0, 1, 0, 0);
    applyStimulus(OP_BRANCH, 3'd2, 7'd0, 0, 0, 0, 0, 0);

    // Memory latency, store path and both timeout boundaries.
    applyStimulus(OP_LOAD, 3'd2, 7'd0, 0, 0, 0, 0, 3);
    applyStimulus(OP_STORE, 3'd2, 7'd0, 0, 0, 0, 0, 0);
    applyStimulus(OP_OP, 3'd0, 7'd0, 0, 0, 0, MEM_TO, 0);
    applyStimulus(OP_OP, 3'd0, 7'd0, 0, 0, 0, MEM_TO - 1, 0);
    applyStimulus(OP_STORE, 3'd0, 7'd0, 0, 0, 0, 0, MEM_TO - 1);
    applyStimulus(OP_LOAD, 3'd0, 7'd0, 0, 0, 0, 0, MEM_TO);

    // Reset asserted while a load waits in MEM.
    applyStimulus(OP_OP, 3'd0, 7'd0, 0, 0, 0, 0, 0);
    bus.instrOpcode = OP_LOAD;
    bus.instrFunct3 = 3'd2;
    bus.instrFunct7 = 7'd0;
    bus.imem_ready  = 1'b1;
    bus.dmem_ready  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("mem_before_reset", 32'(bus.dmem_req), 32'd1);
    @(posedge clk);
    #1;
    reset          = 1'b1;
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    checkOutput("mem_reset_strobes", strobes(), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    model_ret = 0;
    checkOutput("mem_reset_instret", 32'(bus.instret), 32'd0);
    @(negedge clk);
    checkOutput("post_reset_fetch", 32'({bus.imem_req, bus.dmem_req, bus.rf_we}), 32'b100);
    @(posedge clk);
    #1;
    do_reset();

    // Random instructions, including traps and instret wrap-around.
    for (int i = 0; i < 70; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    op = OP_OP;
        2, 3:    op = OP_OPIMM;
        4:       op = OP_LUI;
        5, 6:    op = OP_BRANCH;
        7:       op = OP_LOAD;
        8:       op = OP_STORE;
        default: op = 7'($urandom);
      endcase
      f3   = 3'($urandom);
      pick = $urandom_range(0, 19);
      f7   = (pick < 10) ? 7'd0 : (pick < 17) ? 7'b0100000 : 7'($urandom);
      fw   = ($urandom_range(0, 14) == 0) ? MEM_TO : $urandom_range(0, 2);
      mw   = ($urandom_range(0, 9) == 0) ? MEM_TO : $urandom_range(0, 2);
      applyStimulus(op, f3, f7, 1'($urandom), 1'($urandom), 1'($urandom), fw, mw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I-subset core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and memory ports.
- Consumes opcode/funct3/funct7 fields from the instruction decoder plus ALU flags; drives every datapath enable and select.
- Supported classes: OP, OP-IMM, LUI, BRANCH, LOAD, STORE. Anything else traps.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.
- MEM_TO, 255, max cycles a memory request may wait for ready before bus error (8-bit counter; 1..255).

Ports:
- clk  in  1  core clock, single clock domain
- reset  in  1  synchronous, active-high reset
- instrOpcode  in  7  opcode field of IR
- instrFunct3  in  3  funct3 field of IR
- instrFunct7  in  7  funct7 field of IR
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2
- alu_ltu  in  1  unsigned rs1 < rs2
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction word valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ready  in  1  data access complete this cycle
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = PC+immB
- rf_we  out  1  register file write; rd==0 is discarded by regfile
- wb_sel  out  2  00 ALU, 01 load data, 10 immU
- alu_src_b  out  2  00 rs2, 01 immI, 10 immS
- alu_op  out  4  ALU operation code
- illegal  out  1  sticky: illegal instruction trap
- bus_err  out  1  sticky: memory timeout trap
- instret  out  CNT_W  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset:
  - state=FETCH, instret=0, illegal=0, bus_err=0, timeout counter=0.
  - All strobes (imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we) are forced 0 while reset is high.
  - reset overrides every state, including mid-MEM and TRAP.
- All strobes and selects are combinational from state, IR fields and handshake inputs (Mealy).
- Selects are 0 when unused.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1 that cycle, go to DECODE.
  - Otherwise stay; timeout counter increments.
- DECODE (1 cycle):
  - Legality check. Illegal if any of:
    - opcode not in {0110011, 0010011, 0110111, 1100011, 0000011, 0100011}
    - OP with funct7 not in {0000000, 0100000}
    - OP with funct7=0100000 and funct3 not in {000, 101}
    - OP-IMM funct3=001 with funct7≠0
    - OP-IMM funct3=101 with funct7 not in {0000000, 0100000}
    - BRANCH funct3 in {010, 011}
    - LOAD funct3 not in {000, 001, 010, 100, 101}
    - STORE funct3 > 010
  - Illegal → TRAP. Legal → EXEC.
- alu_op encoding:
  - OP: {funct7[5], funct3}.
  - OP-IMM: {funct3==101 ? funct7[5] : 0, funct3}.
  - BRANCH: 1000 (SUB).
  - LOAD, STORE: 0000 (ADD).
  - Held constant through EXEC, MEM and WB.
- alu_src_b: 01 for OP-IMM and LOAD, 10 for STORE, 00 otherwise.
- EXEC:
  - OP, OP-IMM: rf_we=1, wb_sel=00, pc_we=1, pc_sel=0, instret+1 → FETCH.
  - LUI: rf_we=1, wb_sel=10, pc_we=1, pc_sel=0, instret+1 → FETCH.
  - BRANCH: pc_we=1, pc_sel=taken, instret+1 → FETCH.
    - taken by funct3: 000 alu_zero, 001 !alu_zero, 100 alu_lt, 101 !alu_lt, 110 alu_ltu, 111 !alu_ltu.
  - LOAD, STORE: no writes → MEM.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - On dmem_ready:
    - STORE: pc_we=1, pc_sel=0, instret+1 → FETCH.
    - LOAD: → WB.
- WB: rf_we=1, wb_sel=01, pc_we=1, pc_sel=0, instret+1 → FETCH.
- Latency with zero-wait memory:
  - ALU, LUI, branch: 3 cycles per instruction.
  - Store: 4 cycles. Load: 5 cycles.
  - Each wait cycle adds 1.
- Timeout counter:
  - Cleared on entry to FETCH and MEM; counts each cycle req is high and ready is low.
  - Reaching MEM_TO without ready → TRAP with bus_err=1.
  - ready in the same cycle the count hits MEM_TO wins; no error.
- TRAP:
  - All strobes 0; illegal/bus_err held.
  - Absorbing state; exit only via reset.
  - instret not incremented for the trapping instruction.
- instret wraps modulo 2^CNT_W.

Test Plan:
- Reset high 2 cycles, then imem_ready=1 constant with IR=ADD (opcode 0110011, f3 000, f7 0) → imem_req first cycle after reset, rf_we and pc_we on cycle 3, alu_op=0000, instret=1 after 3 cycles, 3 after 9.
- SRAI (0010011, f3 101, f7 0100000) → alu_op=1101, alu_src_b=01; SUB → 1000; OP f7=0000001 → illegal=1 in TRAP, instret unchanged, no strobes until reset.
- BNE with alu_zero=0 → pc_sel=1 in EXEC; alu_zero=1 → pc_sel=0; BLTU alu_ltu=1 → pc_sel=1; funct3=010 → illegal.
- LW with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then WB with rf_we=1 wb_sel=01; total 8 cycles. SW zero-wait → dmem_we=1, alu_src_b=10, 4 cycles, rf_we never high.
- imem_ready held low with MEM_TO=4 → bus_err=1 after 4 wait cycles. Repeat with ready on the 4th cycle → no error.
- Assert reset during MEM of a load → next cycle state FETCH, all strobes 0 during reset, instret=0, no rf_we.
